vending_fsm: RTL and testbench

//  Transaction controller for the micro vending machine. Takes item selection, coin and

---
 rtl/vending_fsm_if.sv | 31 +++
 rtl/vending_fsm.sv | 155 +++++++++++++++
 tb/tb_vending_fsm.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vending_fsm_if.sv
// Vending transaction bus: selection, coin and cancel pulses toward the
// controller, money/dispense/status results back toward the display stage.
interface vending_fsm_if;
    logic       item_valid;
    logic [1:0] item_sel;
    logic       coin_1;
    logic       coin_5;
    logic       coin_10;
    logic       cancel;
    logic [7:0] need_money;
    logic [7:0] input_money;
    logic [7:0] change_money;
    logic [1:0] item_out;
    logic       dispense;
    logic       coin_reject;
    logic [2:0] state_out;

    // Front panel side: produces the pulses, consumes the results
    modport master (
        output item_valid, item_sel, coin_1, coin_5, coin_10, cancel,
        input  need_money, input_money, change_money, item_out,
               dispense, coin_reject, state_out
    );

    // Controller side
    modport slave (
        input  item_valid, item_sel, coin_1, coin_5, coin_10, cancel,
        output need_money, input_money, change_money, item_out,
               dispense, coin_reject, state_out
    );
endinterface

// File: rtl/vending_fsm.sv
// Transaction controller for the micro vending machine. Latches the selected
// item and its price, accumulates coins up to a display cap, dispenses when
// paid up, refunds on cancel, and holds the result for a fixed time.
module vending_fsm #(
    parameter logic [7:0]  PRICE_0     = 8'd3,
    parameter logic [7:0]  PRICE_1     = 8'd5,
    parameter logic [7:0]  PRICE_2     = 8'd12,
    parameter logic [7:0]  PRICE_3     = 8'd25,
    parameter logic [7:0]  MAX_MONEY   = 8'd99,
    parameter logic [31:0] HOLD_CYCLES = 32'd200_000_000
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    vending_fsm_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PAY      = 3'd1,
        DISPENSE = 3'd2,
        DONE     = 3'd3,
        REFUND   = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  need_money;
    logic [7:0]  input_money;
    logic [7:0]  change_money;
    logic [1:0]  item_out;
    logic [1:0]  sel_item;
    logic        dispense;
    logic        coin_reject;
    logic [31:0] hold_cnt;

    logic [4:0]  coin_sum;
    logic        coin_any;
    logic [8:0]  new_money;
    logic        over_cap;
    logic        paid_up;
    logic [7:0]  sel_price;
    logic        hold_done;

    // Total value of all coins presented this cycle, and the candidate balance
    always_comb begin
        coin_sum  = {4'd0, bus.coin_1}
                  + (bus.coin_5  ? 5'd5  : 5'd0)
                  + (bus.coin_10 ? 5'd10 : 5'd0);
        coin_any  = (coin_sum != 5'd0);
        new_money = {1'b0, input_money} + {4'd0, coin_sum};
        over_cap  = (new_money > {1'b0, MAX_MONEY});
        paid_up   = (new_money >= {1'b0, need_money});
    end

    // Price lookup for the item being selected
    always_comb begin
        sel_price = PRICE_0;
        case (bus.item_sel)
            2'd0:    sel_price = PRICE_0;
            2'd1:    sel_price = PRICE_1;
            2'd2:    sel_price = PRICE_2;
            2'd3:    sel_price = PRICE_3;
            default: sel_price = PRICE_0;
        endcase
    end

    // Last cycle of the result hold; 33-bit compare keeps HOLD_CYCLES=0 sane
    always_comb begin
        hold_done = (({1'b0, hold_cnt} + 33'd1) >= {1'b0, HOLD_CYCLES});
    end

    // Transaction state machine with all outputs registered
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state        <= IDLE;
            need_money   <= '0;
            input_money  <= '0;
            change_money <= '0;
            item_out     <= '0;
            sel_item     <= '0;
            dispense     <= 1'b0;
            coin_reject  <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            dispense    <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    coin_reject <= coin_any;
                    if (bus.item_valid) begin
                        state        <= PAY;
                        need_money   <= sel_price;
                        sel_item     <= bus.item_sel;
                        input_money  <= '0;
                        change_money <= '0;
                    end
                end
                PAY: begin
                    if (bus.cancel) begin
                        state        <= REFUND;
                        change_money <= input_money;
                        coin_reject  <= coin_any;
                        hold_cnt     <= '0;
                    end else if (coin_any) begin
                        if (over_cap) begin
                            coin_reject <= 1'b1;
                        end else if (paid_up) begin
                            state        <= DISPENSE;
                            input_money  <= new_money[7:0];
                            change_money <= new_money[7:0] - need_money;
                            dispense     <= 1'b1;
                            item_out     <= sel_item;
                        end else begin
                            input_money <= new_money[7:0];
                        end
                    end
                end
                DISPENSE: begin
                    state       <= DONE;
                    coin_reject <= coin_any;
                    hold_cnt    <= '0;
                end
                DONE, REFUND: begin
                    coin_reject <= coin_any;
                    if (hold_done) begin
                        state        <= IDLE;
                        need_money   <= '0;
                        input_money  <= '0;
                        change_money <= '0;
                        item_out     <= '0;
                        hold_cnt     <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    need_money   <= '0;
                    input_money  <= '0;
                    change_money <= '0;
                    item_out     <= '0;
                    hold_cnt     <= '0;
                end
            endcase
        end
    end

    assign bus.need_money   = need_money;
    assign bus.input_money  = input_money;
    assign bus.change_money = change_money;
    assign bus.item_out     = item_out;
    assign bus.dispense     = dispense;
    assign bus.coin_reject  = coin_reject;
    assign bus.state_out    = state;

endmodule

// File: tb/tb_vending_fsm.sv
// Self-checking bench for vending_fsm: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_vending_fsm;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 sys_clk = ~sys_clk;

    vending_fsm_if bus();

    vending_fsm #(
        .PRICE_0(8'd3),
        .PRICE_1(8'd5),
        .PRICE_2(8'd12),
        .PRICE_3(8'd99),
        .MAX_MONEY(8'd99),
        .HOLD_CYCLES(32'd8)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    // Observed outputs: state/need/input/change/item/dispense/reject
    logic [30:0] obs;
    assign obs = {bus.state_out, bus.need_money, bus.input_money, bus.change_money,
                  bus.item_out, bus.dispense, bus.coin_reject};

    function automatic logic [30:0] pack(input int st, input int nd, input int inm,
                                         input int ch, input int it, input int d, input int r);
        return {3'(st), 8'(nd), 8'(inm), 8'(ch), 2'(it), 1'(d), 1'(r)};
    endfunction

    // One clock cycle with the given pulses; returns 1 time unit after the edge
    task automatic drive(input logic iv, input logic [1:0] sel, input logic c1,
                         input logic c5, input logic c10, input logic cn);
        bus.item_valid = iv;
        bus.item_sel   = sel;
        bus.coin_1     = c1;
        bus.coin_5     = c5;
        bus.coin_10    = c10;
        bus.cancel     = cn;
        @(posedge sys_clk);
        #1;
        bus.item_valid = 1'b0;
        bus.item_sel   = 2'd0;
        bus.coin_1     = 1'b0;
        bus.coin_5     = 1'b0;
        bus.coin_10    = 1'b0;
        bus.cancel     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        logic [30:0] exp;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        sys_rst = 1'b1;
        idle(2);
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs, exp); end
        checks++;
        sys_rst = 1'b0;
        idle(1);
        if (obs !== exp) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, exp); end
        checks++;
    endtask

    task automatic test_item1_exact;
        logic [30:0] exp;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 5, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL item1_select got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = pack(2, 5, 5, 0, 1, 1, 0);
        if (obs !== exp) begin failures++; $display("FAIL item1_dispense got=%h exp=%h", obs, exp); end
        checks++;
        idle(1);
        exp = pack(3, 5, 5, 0, 1, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL item1_done got=%h exp=%h", obs, exp); end
        checks++;
        idle(8);
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL item1_idle got=%h exp=%h", obs, exp); end
        checks++;
    endtask

    task automatic test_change_and_hold;
        logic [30:0] exp;
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp = pack(1, 12, 10, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL item2_coin10 got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = pack(2, 12, 15, 3, 2, 1, 0);
        if (obs !== exp) begin failures++; $display("FAIL item2_dispense got=%h exp=%h", obs, exp); end
        checks++;
        idle(1);
        exp = pack(3, 12, 15, 3, 2, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL item2_done_first got=%h exp=%h", obs, exp); end
        checks++;
        idle(7);
        if (obs !== exp) begin failures++; $display("FAIL item2_done_last got=%h exp=%h", obs, exp); end
        checks++;
        idle(1);
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL item2_back_idle got=%h exp=%h", obs, exp); end
        checks++;
    endtask

    task automatic test_cancel_refund;
        logic [30:0] exp;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        exp = pack(4, 99, 10, 10, 0, 0, 1);
        if (obs !== exp) begin failures++; $display("FAIL cancel_refund got=%h exp=%h", obs, exp); end
        checks++;
        idle(1);
        exp = pack(4, 99, 10, 10, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL refund_reject_pulse got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = pack(4, 99, 10, 10, 0, 0, 1);
        if (obs !== exp) begin failures++; $display("FAIL refund_coin got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp = pack(4, 99, 10, 10, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL refund_ignore got=%h exp=%h", obs, exp); end
        checks++;
        idle(4);
        if (obs !== exp) begin failures++; $display("FAIL refund_hold_last got=%h exp=%h", obs, exp); end
        checks++;
        idle(1);
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL refund_idle got=%h exp=%h", obs, exp); end
        checks++;
    endtask

    task automatic test_money_cap;
        logic [30:0] exp;
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            exp = pack(1, 99, 10 * k, 0, 0, 0, 0);
            if (obs !== exp) begin failures++; $display("FAIL cap_accum_%0d got=%h exp=%h", k, obs, exp); end
            checks++;
        end
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp = pack(1, 99, 90, 0, 0, 0, 1);
        if (obs !== exp) begin failures++; $display("FAIL cap_reject got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = pack(1, 99, 95, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL cap_coin5 got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 99, 96, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL pay_ignore_item got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = pack(2, 99, 99, 0, 3, 1, 0);
        if (obs !== exp) begin failures++; $display("FAIL cap_exact_max got=%h exp=%h", obs, exp); end
        checks++;
        idle(9);
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL cap_idle got=%h exp=%h", obs, exp); end
        checks++;
    endtask

    task automatic test_idle_coin_and_multi;
        logic [30:0] exp;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 0, 0, 0, 1);
        if (obs !== exp) begin failures++; $display("FAIL idle_coin got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 12, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL b2b_select got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        exp = pack(2, 12, 16, 4, 2, 1, 0);
        if (obs !== exp) begin failures++; $display("FAIL multi_coin got=%h exp=%h", obs, exp); end
        checks++;
        idle(9);
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL multi_idle got=%h exp=%h", obs, exp); end
        checks++;
    endtask

    task automatic test_async_reset;
        logic [30:0] exp;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        exp = pack(1, 5, 1, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL pre_reset got=%h exp=%h", obs, exp); end
        checks++;
        #3 sys_rst = 1'b1;
        #1;
        exp = pack(0, 0, 0, 0, 0, 0, 0);
        if (obs !== exp) begin failures++; $display("FAIL async_reset got=%h exp=%h", obs, exp); end
        checks++;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        if (obs !== exp) begin failures++; $display("FAIL reset_held got=%h exp=%h", obs, exp); end
        checks++;
        #2 sys_rst = 1'b0;
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        exp = pack(0, 0, 0, 0, 0, 0, 1);
        if (obs !== exp) begin failures++; $display("FAIL after_reset got=%h exp=%h", obs, exp); end
        checks++;
        idle(1);
    endtask

    // Randomized traffic against a transaction-level model: the model keeps
    // price, amount paid and remaining hold time, and applies the rules directly.
    task automatic test_random;
        int price[4] = '{3, 5, 12, 99};
        int m_st, m_need, m_in, m_ch, m_item, m_out, m_disp, m_rej, m_left;
        logic iv, c1, c5, c10, cn;
        logic [1:0] sel;
        int coins;
        logic [30:0] exp;
        m_st = 0; m_need = 0; m_in = 0; m_ch = 0; m_item = 0; m_out = 0; m_left = 0;
        for (int n = 0; n < 600; n++) begin
            iv  = ($urandom_range(3) == 0);
            sel = 2'($urandom_range(3));
            c1  = ($urandom_range(3) == 0);
            c5  = ($urandom_range(3) == 0);
            c10 = ($urandom_range(3) == 0);
            cn  = ($urandom_range(15) == 0);
            coins  = (c1 ? 1 : 0) + (c5 ? 5 : 0) + (c10 ? 10 : 0);
            m_disp = 0;
            m_rej  = (coins > 0) ? 1 : 0;
            if (m_st == 0) begin
                if (iv) begin
                    m_st = 1; m_need = price[sel]; m_item = sel; m_in = 0; m_ch = 0;
                end
            end else if (m_st == 1) begin
                if (cn) begin
                    m_st = 4; m_ch = m_in; m_left = 8;
                end else if (coins > 0) begin
                    if (m_in + coins > 99) begin
                        m_rej = 1;
                    end else if (m_in + coins >= m_need) begin
                        m_in = m_in + coins; m_ch = m_in - m_need;
                        m_disp = 1; m_out = m_item; m_st = 2; m_rej = 0;
                    end else begin
                        m_in = m_in + coins; m_rej = 0;
                    end
                end
            end else if (m_st == 2) begin
                m_st = 3; m_left = 8;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_st = 0; m_need = 0; m_in = 0; m_ch = 0; m_out = 0;
                end
            end
            drive(iv, sel, c1, c5, c10, cn);
            exp = pack(m_st, m_need, m_in, m_ch, m_out, m_disp, m_rej);
            if (obs !== exp) begin failures++; $display("FAIL random_%0d got=%h exp=%h", n, obs, exp); end
            checks++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus.item_valid = 1'b0;
        bus.item_sel   = 2'd0;
        bus.coin_1     = 1'b0;
        bus.coin_5     = 1'b0;
        bus.coin_10    = 1'b0;
        bus.cancel     = 1'b0;
        #1 sys_rst = 1'b1;
        test_reset;
        test_item1_exact;
        test_change_and_hold;
        test_cancel_refund;
        test_money_cap;
        test_idle_coin_and_multi;
        test_async_reset;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
